// File: rtl/tlc_param.sv
// Parametrised traffic light controller: demand-weighted arbitration with round-robin
// tie-break, starvation forcing, green extension and a maintenance flashing-yellow mode.
module tlc_param #(
    parameter int N_DIR      = 4,
    parameter int SENSOR_W   = 2,
    parameter int GREEN_CYC  = 30,
    parameter int YELLOW_CYC = 10,
    parameter int ALLRED_CYC = 2,
    parameter int MAX_WAIT   = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset_b,
    input  logic [N_DIR*SENSOR_W-1:0]     i_sensor,
    input  logic                          i_flash,
    output logic [N_DIR-1:0]              o_red,
    output logic [N_DIR-1:0]              o_yellow,
    output logic [N_DIR-1:0]              o_green,
    output logic [$clog2(N_DIR)-1:0]      o_active,
    output logic [2:0]                    o_state
);

    localparam int AW   = $clog2(N_DIR);
    localparam int MAXC = (GREEN_CYC > YELLOW_CYC)
                        ? ((GREEN_CYC > ALLRED_CYC) ? GREEN_CYC : ALLRED_CYC)
                        : ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
    localparam int TW   = $clog2(MAXC);
    localparam int WW   = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ALLRED    = 3'd0,
        GREEN     = 3'd1,
        YELLOW    = 3'd2,
        FLASH_ON  = 3'd3,
        FLASH_OFF = 3'd4
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [AW-1:0]       r_active;
    logic [WW-1:0]       r_wait [N_DIR];

    logic [SENSOR_W-1:0] w_sense [N_DIR];
    logic [AW-1:0]       w_next;
    logic [AW-1:0]       w_scanIdx;
    logic [AW-1:0]       w_starvIdx;
    logic [AW-1:0]       w_bestIdx;
    logic [AW-1:0]       w_winner;
    logic [SENSOR_W-1:0] w_bestVal;
    logic                w_starved;
    logic                w_othersIdle;
    logic                w_extend;

    always_comb begin
        for (int k = 0; k < N_DIR; k++) begin
            w_sense[k] = i_sensor[k*SENSOR_W +: SENSOR_W];
        end
    end

    assign w_next = (r_active == AW'(N_DIR - 1)) ? '0 : r_active + 1'b1;

    // Scan starts just after the last grant, so strict compares give round-robin tie-break.
    always_comb begin
        w_starved  = 1'b0;
        w_starvIdx = '0;
        w_bestIdx  = w_next;
        w_bestVal  = '0;
        w_scanIdx  = '0;
        for (int i = 0; i < N_DIR; i++) begin
            w_scanIdx = AW'((int'(r_active) + 1 + i) % N_DIR);
            if (!w_starved && w_sense[w_scanIdx] != '0 && r_wait[w_scanIdx] == WW'(MAX_WAIT)) begin
                w_starved  = 1'b1;
                w_starvIdx = w_scanIdx;
            end
            if (w_sense[w_scanIdx] > w_bestVal) begin
                w_bestVal = w_sense[w_scanIdx];
                w_bestIdx = w_scanIdx;
            end
        end
        w_winner = w_starved ? w_starvIdx : w_bestIdx;
    end

    always_comb begin
        w_othersIdle = 1'b1;
        for (int k = 0; k < N_DIR; k++) begin
            if (AW'(k) != r_active && w_sense[k] != '0) begin
                w_othersIdle = 1'b0;
            end
        end
        w_extend = (w_sense[r_active] != '0) && w_othersIdle;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_b) begin
            r_state  <= ALLRED;
            r_timer  <= TW'(ALLRED_CYC - 1);
            r_active <= AW'(N_DIR - 1);
            for (int k = 0; k < N_DIR; k++) begin
                r_wait[k] <= '0;
            end
        end else begin
            unique case (r_state)
                ALLRED: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (i_flash) begin
                        r_state <= FLASH_ON;
                        r_timer <= TW'(YELLOW_CYC - 1);
                    end else begin
                        r_state  <= GREEN;
                        r_timer  <= TW'(GREEN_CYC - 1);
                        r_active <= w_winner;
                        for (int k = 0; k < N_DIR; k++) begin
                            if (AW'(k) == w_winner || w_sense[k] == '0) begin
                                r_wait[k] <= '0;
                            end else if (r_wait[k] != WW'(MAX_WAIT)) begin
                                r_wait[k] <= r_wait[k] + 1'b1;
                            end
                        end
                    end
                end
                GREEN: begin
                    // Flash truncation wins over extension, even on the expiry cycle.
                    if (i_flash || (r_timer == '0 && !w_extend)) begin
                        r_state <= YELLOW;
                        r_timer <= TW'(YELLOW_CYC - 1);
                    end else if (r_timer == '0) begin
                        r_timer <= TW'(GREEN_CYC - 1);
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                YELLOW: begin
                    if (r_timer == '0) begin
                        r_state <= ALLRED;
                        r_timer <= TW'(ALLRED_CYC - 1);
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                FLASH_ON, FLASH_OFF: begin
                    if (!i_flash) begin
                        r_state <= ALLRED;
                        r_timer <= TW'(ALLRED_CYC - 1);
                    end else if (r_timer == '0) begin
                        r_state <= (r_state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        r_timer <= TW'(YELLOW_CYC - 1);
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= ALLRED;
                    r_timer <= TW'(ALLRED_CYC - 1);
                end
            endcase
        end
    end

    always_comb begin
        o_red    = '0;
        o_yellow = '0;
        o_green  = '0;
        unique case (r_state)
            ALLRED: o_red = '1;
            GREEN: begin
                o_red             = '1;
                o_red[r_active]   = 1'b0;
                o_green[r_active] = 1'b1;
            end
            YELLOW: begin
                o_red              = '1;
                o_red[r_active]    = 1'b0;
                o_yellow[r_active] = 1'b1;
            end
            FLASH_ON:  o_yellow = '1;
            FLASH_OFF: o_yellow = '0;
            default:   o_red = '1;
        endcase
    end

    assign o_active = r_active;
    assign o_state  = r_state;

endmodule

// File: tb/tb_tlc_param.sv
// Self-checking bench for tlc_param: a per-cycle phase model plus directed scenarios
// with hand-derived grant orders and phase lengths.
module tb_tlc_param;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int G  = 30;
    localparam int Y  = 10;
    localparam int AR = 2;
    localparam int MW = 3;

    localparam int P_ALLRED = 0, P_GREEN = 1, P_YELLOW = 2, P_FON = 3, P_FOFF = 4;

    logic                i_clock = 1'b0;
    logic                i_reset_b = 1'b0;
    logic [N*SW-1:0]     i_sensor = '0;
    logic                i_flash = 1'b0;
    logic [N-1:0]        o_red, o_yellow, o_green;
    logic [1:0]          o_active;
    logic [2:0]          o_state;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;
    logic [2:0] prevState = 3'd0;

    int mPhase, mLeft, mActive;
    int mWait [N];
    int mGrants [$];
    int dGrants [$];

    tlc_param #(
        .N_DIR(N), .SENSOR_W(SW), .GREEN_CYC(G), .YELLOW_CYC(Y),
        .ALLRED_CYC(AR), .MAX_WAIT(MW)
    ) dut (
        .i_clock(i_clock), .i_reset_b(i_reset_b), .i_sensor(i_sensor), .i_flash(i_flash),
        .o_red(o_red), .o_yellow(o_yellow), .o_green(o_green),
        .o_active(o_active), .o_state(o_state)
    );

    always #5 i_clock = ~i_clock;

    function automatic int sensOf(input logic [N*SW-1:0] s, input int k);
        return int'(s[k*SW +: SW]);
    endfunction

    // Starved demanders first, then heaviest demand, scanning from the approach after the last grant.
    function automatic int arbitrate(input logic [N*SW-1:0] s);
        int order [N];
        int best, bestV;
        for (int i = 0; i < N; i++) order[i] = (mActive + 1 + i) % N;
        for (int i = 0; i < N; i++)
            if (sensOf(s, order[i]) > 0 && mWait[order[i]] == MW) return order[i];
        best = order[0];
        bestV = sensOf(s, order[0]);
        for (int i = 1; i < N; i++)
            if (sensOf(s, order[i]) > bestV) begin
                best = order[i];
                bestV = sensOf(s, order[i]);
            end
        return best;
    endfunction

    // Model: phase name plus cycles remaining in it, advanced once per rising edge.
    always @(posedge i_clock) begin
        if (i_reset_b) begin
            mPhase = P_ALLRED;
            mLeft = AR;
            mActive = N - 1;
            for (int k = 0; k < N; k++) mWait[k] = 0;
            mGrants.delete();
        end else begin
            case (mPhase)
                P_ALLRED:
                    if (mLeft > 1) mLeft--;
                    else if (i_flash) begin
                        mPhase = P_FON;
                        mLeft = Y;
                    end else begin
                        int w;
                        w = arbitrate(i_sensor);
                        for (int k = 0; k < N; k++) begin
                            if (k == w || sensOf(i_sensor, k) == 0) mWait[k] = 0;
                            else if (mWait[k] < MW) mWait[k]++;
                        end
                        mActive = w;
                        mGrants.push_back(w);
                        mPhase = P_GREEN;
                        mLeft = G;
                    end
                P_GREEN: begin
                    int others;
                    others = 0;
                    for (int k = 0; k < N; k++) if (k != mActive) others += sensOf(i_sensor, k);
                    if (i_flash) begin
                        mPhase = P_YELLOW;
                        mLeft = Y;
                    end else if (mLeft > 1) mLeft--;
                    else if (sensOf(i_sensor, mActive) != 0 && others == 0) mLeft = G;
                    else begin
                        mPhase = P_YELLOW;
                        mLeft = Y;
                    end
                end
                P_YELLOW:
                    if (mLeft > 1) mLeft--;
                    else begin
                        mPhase = P_ALLRED;
                        mLeft = AR;
                    end
                default:
                    if (!i_flash) begin
                        mPhase = P_ALLRED;
                        mLeft = AR;
                    end else if (mLeft > 1) mLeft--;
                    else begin
                        mPhase = (mPhase == P_FON) ? P_FOFF : P_FON;
                        mLeft = Y;
                    end
            endcase
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every elapsed cycle goes through here, so the model comparison runs on each falling edge.
    task automatic tick(input int n);
        logic [N-1:0] eR, eY, eG;
        bit lampOk;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clock);
            if (i_reset_b) dGrants.delete();
            if (checkEn) begin
                eR = '0;
                eY = '0;
                eG = '0;
                case (mPhase)
                    P_ALLRED: eR = '1;
                    P_GREEN: begin
                        eG = 4'(1) << mActive;
                        eR = ~eG;
                    end
                    P_YELLOW: begin
                        eY = 4'(1) << mActive;
                        eR = ~eY;
                    end
                    P_FON: eY = '1;
                    default: ;
                endcase
                checkOutput("cycle {state,active,red,yellow,green}",
                            int'({o_state, o_active, o_red, o_yellow, o_green}),
                            int'({3'(mPhase), 2'(mActive), eR, eY, eG}));
                checkOutput("green onehot", int'($countones(o_green) <= 1), 1);
                if (o_state < 3'd3) begin
                    lampOk = 1'b1;
                    for (int k = 0; k < N; k++)
                        if (int'(o_red[k]) + int'(o_yellow[k]) + int'(o_green[k]) != 1) lampOk = 1'b0;
                    checkOutput("one lamp per approach", int'(lampOk), 1);
                end
                if (o_state == 3'd1 && prevState == 3'd0) dGrants.push_back(int'(o_active));
                prevState = o_state;
            end
        end
    endtask

    task automatic applyStimulus(input logic [N*SW-1:0] sens, input logic flash);
        i_sensor = sens;
        i_flash = flash;
    endtask

    task automatic applyReset();
        i_reset_b = 1'b1;
        tick(2);
        checkEn = 1'b1;
        i_reset_b = 1'b0;
    endtask

    task automatic waitState(input string name, input int target, input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (int'(o_state) != target && n < budget);
        if (int'(o_state) != target) checkOutput({name, " timeout"}, int'(o_state), target);
    endtask

    task automatic waitGrants(input int count, input int budget);
        int n;
        n = 0;
        while (dGrants.size() < count && n < budget) begin
            tick(1);
            n++;
        end
        if (dGrants.size() < count) checkOutput("grant wait timeout", dGrants.size(), count);
    endtask

    task automatic checkGrantList(input string name, input int e [5], input int count);
        for (int i = 0; i < count; i++) begin
            checkOutput({name, " model grant"}, (i < mGrants.size()) ? mGrants[i] : -1, e[i]);
            checkOutput({name, " dut grant"}, (i < dGrants.size()) ? dGrants[i] : -1, e[i]);
        end
    endtask

    initial begin
        int n;
        int e [5];

        // All sensors idle: plain round-robin with exact phase lengths.
        applyStimulus('0, 1'b0);
        applyReset();
        checkOutput("reset state", int'(o_state), 0);
        checkOutput("reset red", int'(o_red), 4'hF);
        checkOutput("reset yellow", int'(o_yellow), 0);
        checkOutput("reset green", int'(o_green), 0);
        checkOutput("reset active", int'(o_active), 3);
        waitState("first green", 1, 10, n);
        checkOutput("allred length", n, AR);
        checkOutput("first green lamp", int'(o_green), 4'b0001);
        waitState("yellow", 2, 50, n);
        checkOutput("green length", n, G);
        waitState("allred", 0, 20, n);
        checkOutput("yellow length", n, Y);
        waitGrants(5, 5 * (G + Y + AR) + 10);
        e = '{0, 1, 2, 3, 0};
        checkGrantList("idle rr", e, 5);

        // W=3 S=2 E=1 N=0: W wins until S starves, then E starves.
        applyStimulus(8'b00_01_10_11, 1'b0);
        applyReset();
        waitGrants(5, 5 * (G + Y + AR) + 10);
        e = '{0, 0, 0, 1, 2};
        checkGrantList("weighted", e, 5);

        // S alone extends; E arrival ends green at the next boundary.
        applyStimulus(8'b00_00_11_00, 1'b0);
        applyReset();
        waitState("S green", 1, 10, n);
        checkOutput("S granted", int'(o_active), 1);
        tick(65);
        checkOutput("S extended state", int'(o_state), 1);
        checkOutput("S extended active", int'(o_active), 1);
        applyStimulus(8'b00_01_11_00, 1'b0);
        waitState("S yellow", 2, 40, n);
        checkOutput("extension boundary", n, 3 * G - 65);
        applyStimulus(8'b00_01_00_00, 1'b0);
        waitState("E green", 1, 30, n);
        checkOutput("E granted", int'(o_active), 2);

        // Equal demand: strict round-robin.
        applyStimulus(8'b01_01_01_01, 1'b0);
        applyReset();
        waitGrants(4, 4 * (G + Y + AR) + 10);
        e = '{0, 1, 2, 3, 0};
        checkGrantList("equal rr", e, 4);

        // Flash request at green cycle 5, then release.
        applyStimulus('0, 1'b0);
        applyReset();
        waitState("flash green", 1, 10, n);
        tick(4);
        applyStimulus('0, 1'b1);
        waitState("truncate", 2, 5, n);
        checkOutput("truncate latency", n, 1);
        waitState("flash allred", 0, 20, n);
        checkOutput("truncated yellow length", n, Y);
        waitState("flash on", 3, 10, n);
        checkOutput("allred before flash", n, AR);
        checkOutput("flash on lamps", int'({o_red, o_yellow, o_green}), 12'h0F0);
        waitState("flash off", 4, 20, n);
        checkOutput("flash on length", n, Y);
        checkOutput("flash off lamps", int'({o_red, o_yellow, o_green}), 0);
        waitState("flash on 2", 3, 20, n);
        checkOutput("flash off length", n, Y);
        applyStimulus('0, 1'b0);
        waitState("flash exit", 0, 3, n);
        checkOutput("flash exit latency", n, 1);
        waitState("post flash green", 1, 10, n);
        checkOutput("post flash allred", n, AR);
        checkOutput("post flash active", int'(o_active), 1);

        // Reset mid-yellow.
        waitState("pre reset yellow", 2, 50, n);
        tick(3);
        i_reset_b = 1'b1;
        tick(1);
        checkOutput("midreset state", int'(o_state), 0);
        checkOutput("midreset lamps", int'({o_red, o_yellow, o_green}), 12'hF00);
        checkOutput("midreset active", int'(o_active), 3);
        i_reset_b = 1'b0;
        waitState("restart green", 1, 10, n);
        checkOutput("restart allred", n, AR);
        checkOutput("restart active", int'(o_active), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlc_param.md
# tlc_param

Parametrised traffic light controller, the successor to the fixed four-way `tlc`. It supports N approaches and configurable sensor width, and generates its green, yellow and all-red phase timing internally instead of taking external timer strobes. It grants green to the approach with the heaviest sensor demand, uses round-robin tie-break and starvation protection, and adds green extension and a maintenance flashing-yellow mode. The block sits at the top of the intersection datapath and drives the lamp outputs directly.

## Interface
- N_DIR, 4, number of approaches (index 0=west, 1=south, 2=east, 3=north when N_DIR=4); 2..8
- SENSOR_W, 2, width of each approach's queue-level sensor
- GREEN_CYC, 30, cycles per green interval; >=2
- YELLOW_CYC, 10, cycles per yellow interval and per flash half-period; >=1
- ALLRED_CYC, 2, cycles of all-red clearance; >=1
- MAX_WAIT, 3, number of consecutive lost grants before a demanding approach is forced; >=1
- i_clock  in  1  clock; all logic is rising-edge
- i_reset_b  in  1  reset, synchronous, active-high (1 = in reset)
- i_sensor  in  N_DIR*SENSOR_W  demand level; approach k occupies bits [k*SENSOR_W +: SENSOR_W]; 0 = no car
- i_flash  in  1  maintenance request: enter flashing-yellow mode
- o_red  out  N_DIR  red lamp per approach
- o_yellow  out  N_DIR  yellow lamp per approach
- o_green  out  N_DIR  green lamp per approach
- o_active  out  clog2(N_DIR)  approach currently or last granted
- o_state  out  3  encoding: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH_ON, 4 FLASH_OFF

## Operation
- Moore FSM. States: ALLRED, GREEN, YELLOW, FLASH_ON, FLASH_OFF. Lamps decode from registered state and o_active only.
- Lamp decode by state:
  - GREEN: o_green[active]=1 and o_red=1 elsewhere.
  - YELLOW: o_yellow[active]=1 and o_red=1 elsewhere.
  - ALLRED: all o_red=1.
  - FLASH_ON: all o_yellow=1 and nothing else.
  - FLASH_OFF: all lamps 0.
- Reset values:
  - state=ALLRED, timer=ALLRED_CYC-1, o_red=all 1, o_yellow=0, o_green=0.
  - o_active=N_DIR-1, so the first round-robin grant is approach 0.
  - All wait counters 0.
- Down-counter timer: each state lasts exactly its programmed cycles. The state advances on the cycle the timer reads 0. Timer width is clog2(max(GREEN_CYC,YELLOW_CYC,ALLRED_CYC)).
- Arbitration runs in the last ALLRED cycle on the i_sensor value sampled that cycle. The winner becomes o_active and GREEN starts on the next cycle. Priority order:
  1. Starved approaches: wait counter == MAX_WAIT and sensor != 0. Pick the first found scanning from (o_active+1) mod N_DIR.
  2. Otherwise, the highest sensor value. Ties go to the first found scanning from (o_active+1) mod N_DIR.
  3. If all sensors are 0, pick (o_active+1) mod N_DIR; the controller keeps cycling.
- Wait counters, updated at each grant:
  - The winner clears to 0.
  - Every other approach with sensor != 0 increments, saturating at MAX_WAIT.
  - Approaches with sensor == 0 clear to 0.
- Green extension: at GREEN expiry, the timer reloads GREEN_CYC-1 and GREEN continues if both conditions hold:
  - the active sensor is != 0;
  - every other sensor is 0.
  Otherwise the FSM goes to YELLOW.
- YELLOW expiry goes to ALLRED.
- Flash entry. i_flash is sampled every cycle.
  - In GREEN, i_flash=1 truncates green: YELLOW starts on the next cycle with a full YELLOW_CYC.
  - In YELLOW, the FSM finishes the yellow interval.
  - On ALLRED expiry with i_flash=1, the FSM enters FLASH_ON instead of arbitrating.
- Flash operation: FLASH_ON and FLASH_OFF alternate every YELLOW_CYC cycles.
- Flash exit: i_flash=0 in either flash state moves to ALLRED on the next cycle with a full ALLRED_CYC, then arbitrates normally. o_active is unchanged through flash.

## Timing
- Normal cycle with no extension: GREEN_CYC + YELLOW_CYC + ALLRED_CYC cycles per grant.
- Sensor-to-grant latency: a sensor change is seen only at the last ALLRED cycle. Grant is visible on lamps 1 cycle later.
- Reset asserted mid-operation: the next edge forces the reset values regardless of state. There are no intermediate lamp states.
- Invariants, every cycle:
  - popcount(o_green) <= 1.
  - In non-flash states, each approach has exactly one lamp lit.
  - GREEN is never entered directly from YELLOW or GREEN of a different approach; ALLRED always intervenes.
- Flash asserted on the same cycle as GREEN expiry: this is treated as truncation. YELLOW follows and no extension applies.

## Test plan
- Reset, all sensors 0: ALLRED for 2 cycles, then approach 0 GREEN for 30 cycles, YELLOW 10, ALLRED 2. Next grants are 1, 2, 3, 0. o_green is never multi-hot.
- Sensors W=11 S=10 E=01 N=00: first grant W. Extension must not occur. Subsequent grants follow the priority rules. Expected order: W, W, W, then S once its wait counter reaches 3. Check each grant against an arbitration model.
- Only S=11, others 0: S GREEN extends repeatedly. Raise E=01 mid-green: S ends at the next 30-cycle boundary, then YELLOW, ALLRED, E GREEN.
- Equal sensors, all 01: grants are strict round-robin 0, 1, 2, 3.
- i_flash=1 at cycle 5 of GREEN: YELLOW on the next cycle for 10 cycles, ALLRED 2, then yellow toggling every 10 cycles with red and green off. Drop i_flash: ALLRED 2, then arbitration resumes.
- Reset pulsed during YELLOW: outputs equal the reset values on the next edge, and the sequence restarts at approach 0.
